alu_sequencer: RTL and testbench

- Issuing-side controller for the 8-bit ALU: accepts operation commands over a valid/ready handshake and drives the ALU's `mode_select`, `input_A` and `input_B`.
- Samples the ALU's `output_C` and `flags` into registers and returns them over a valid/ready result channel.
- Supports double-word (2×WORD_SIZE) operations by issuing two back-to-back ALU passes, with carry chaining via the ALU's ADC/SBB modes.
- Sits between the instruction decode/execute stage and the combinational ALU.

---
 rtl/alu_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_alu_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_sequencer                                                 |
// | Purpose  : Issuing-side controller for a combinational 8-bit ALU.        |
// |            Accepts a command over valid/ready and drives the ALU mode    |
// |            and operands. It captures the ALU result and flags, and       |
// |            returns them over a valid/ready result channel. Double-word   |
// |            ops run two back-to-back passes. The high pass uses ADC/SBB   |
// |            so the carry chains across the two bytes.                     |
// | Ports    : clk, rst            - clock, synchronous active-high reset    |
// |            cmd_valid/ready     - command handshake                       |
// |            cmd_op/wide/a/b     - command payload                         |
// |            alu_mode/a/b        - registered drive to the ALU             |
// |            alu_c/alu_flags     - ALU response                            |
// |            result_valid/ready  - result handshake                        |
// |            result_data/flags   - operation result                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module alu_sequencer #(
  parameter int WORD_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic                   cmd_wide,
  input  logic [2*WORD_SIZE-1:0] cmd_a,
  input  logic [2*WORD_SIZE-1:0] cmd_b,
  output logic [3:0]             alu_mode,
  output logic [WORD_SIZE-1:0]   alu_a,
  output logic [WORD_SIZE-1:0]   alu_b,
  input  logic [WORD_SIZE-1:0]   alu_c,
  input  logic [7:0]             alu_flags,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [2*WORD_SIZE-1:0] result_data,
  output logic [7:0]             result_flags
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC_LO = 2'd1,
    S_EXEC_HI = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             op_q, op_d;
  logic                   wide_q, wide_d;
  logic [2*WORD_SIZE-1:0] a_q, a_d;
  logic [2*WORD_SIZE-1:0] b_q, b_d;
  logic [WORD_SIZE-1:0]   lo_result_q, lo_result_d;
  logic [7:0]             lo_flags_q, lo_flags_d;
  logic [3:0]             alu_mode_q, alu_mode_d;
  logic [WORD_SIZE-1:0]   alu_a_q, alu_a_d;
  logic [WORD_SIZE-1:0]   alu_b_q, alu_b_d;
  logic                   cmd_ready_q, cmd_ready_d;
  logic                   result_valid_q, result_valid_d;
  logic [2*WORD_SIZE-1:0] result_data_q, result_data_d;
  logic [7:0]             result_flags_q, result_flags_d;

  logic                   w_wide_ok;
  logic                   w_zero_op;
  logic [3:0]             w_hi_mode;

  // Only add/sub and the bitwise ops make sense split across two bytes.
  assign w_wide_ok = cmd_op inside {4'd6, 4'd8, 4'd11, 4'd12, 4'd13, 4'd14};
  // These modes leave output_C undefined, so only their flags are reported.
  assign w_zero_op = op_q inside {4'd0, 4'd2, 4'd3, 4'd15};
  // The high pass of add/sub must consume the carry/borrow of the low pass.
  assign w_hi_mode = (op_q == 4'd6) ? 4'd7 :
                     (op_q == 4'd8) ? 4'd9 : op_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    wide_d         = wide_q;
    a_d            = a_q;
    b_d            = b_q;
    lo_result_d    = lo_result_q;
    lo_flags_d     = lo_flags_q;
    alu_mode_d     = 4'd0;
    alu_a_d        = '0;
    alu_b_d        = '0;
    cmd_ready_d    = cmd_ready_q;
    result_valid_d = result_valid_q;
    result_data_d  = result_data_q;
    result_flags_d = result_flags_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = cmd_op;
          wide_d      = cmd_wide & w_wide_ok;
          a_d         = cmd_a;
          b_d         = cmd_b;
          // ALU drive is registered, so the low pass is set up here.
          alu_mode_d  = cmd_op;
          alu_a_d     = cmd_a[WORD_SIZE-1:0];
          alu_b_d     = cmd_b[WORD_SIZE-1:0];
          cmd_ready_d = 1'b0;
          state_d     = S_EXEC_LO;
        end
      end

      S_EXEC_LO: begin
        lo_result_d = alu_c;
        lo_flags_d  = alu_flags;
        if (wide_q) begin
          alu_mode_d = w_hi_mode;
          alu_a_d    = a_q[2*WORD_SIZE-1:WORD_SIZE];
          alu_b_d    = b_q[2*WORD_SIZE-1:WORD_SIZE];
          state_d    = S_EXEC_HI;
        end else begin
          result_valid_d = 1'b1;
          result_data_d  = w_zero_op ? '0 : {{WORD_SIZE{1'b0}}, alu_c};
          result_flags_d = {alu_flags[7:4], 4'b0000};
          state_d        = S_RESP;
        end
      end

      S_EXEC_HI: begin
        result_valid_d = 1'b1;
        result_data_d  = w_zero_op ? '0 : {alu_c, lo_result_q};
        // Whole-word zero needs both halves zero; sign/carry/overflow
        // come from the most significant pass.
        result_flags_d = {lo_flags_q[7] & alu_flags[7], alu_flags[6:4], 4'b0000};
        state_d        = S_RESP;
      end

      S_RESP: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          cmd_ready_d    = 1'b1;
          state_d        = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      op_q           <= 4'd0;
      wide_q         <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      lo_result_q    <= '0;
      lo_flags_q     <= 8'd0;
      alu_mode_q     <= 4'd0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      cmd_ready_q    <= 1'b1;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      result_flags_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      wide_q         <= wide_d;
      a_q            <= a_d;
      b_q            <= b_d;
      lo_result_q    <= lo_result_d;
      lo_flags_q     <= lo_flags_d;
      alu_mode_q     <= alu_mode_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      cmd_ready_q    <= cmd_ready_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      result_flags_q <= result_flags_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign alu_mode     = alu_mode_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign result_flags = result_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_alu_sequencer                                              |
// | Purpose  : Self-checking bench for alu_sequencer. A behavioural 8-bit    |
// |            ALU with a carry register answers the sequencer. Expected     |
// |            results are computed at full word width and queued. A         |
// |            monitor compares each presented result against the queue.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_op = 4'd0;
  logic        cmd_wide = 1'b0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic [3:0]  alu_mode;
  logic [7:0]  alu_a, alu_b, alu_c;
  logic [7:0]  alu_flags;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [15:0] result_data;
  logic [7:0]  result_flags;

  alu_sequencer #(.WORD_SIZE(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_wide(cmd_wide), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_c(alu_c), .alu_flags(alu_flags),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_flags(result_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural ALU ----------------
  // Returns {flags, c}. Low nibble of flags is deliberately non-zero.
  function automatic logic [15:0] alu_fn(input logic [3:0] m, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic        c, v;
    c = 1'b0; v = 1'b0; s = 9'd0; p = 16'd0;
    case (m)
      4'd6:  begin s = {1'b0,a} + {1'b0,b};              r = s[7:0]; c = s[8]; v = (a[7]==b[7]) && (r[7]!=a[7]); end
      4'd7:  begin s = {1'b0,a} + {1'b0,b} + {8'd0,cin}; r = s[7:0]; c = s[8]; v = (a[7]==b[7]) && (r[7]!=a[7]); end
      4'd8:  begin s = {1'b0,a} - {1'b0,b};              r = s[7:0]; c = s[8]; v = (a[7]!=b[7]) && (r[7]!=a[7]); end
      4'd9:  begin s = {1'b0,a} - {1'b0,b} - {8'd0,cin}; r = s[7:0]; c = s[8]; v = (a[7]!=b[7]) && (r[7]!=a[7]); end
      4'd10: begin p = a * b; r = p[7:0]; c = |p[15:8]; end
      4'd11: r = a & b;
      4'd12: r = a | b;
      4'd13: r = a ^ b;
      4'd14: r = ~a;
      default: r = a ^ b ^ {m, m};
    endcase
    return {r == 8'd0, r[7], c, v, 4'b1010, r};
  endfunction

  logic carry_q = 1'b0;
  logic [15:0] alu_out;
  assign alu_out   = alu_fn(alu_mode, alu_a, alu_b, carry_q);
  assign alu_c     = alu_out[7:0];
  assign alu_flags = alu_out[15:8];
  always @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else if (alu_mode != 4'd0) carry_q <= alu_flags[5];
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] data;
    logic [7:0]  flags;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  function automatic logic eff_wide(input logic [3:0] op, input logic w);
    return w && (op inside {4'd6, 4'd8, 4'd11, 4'd12, 4'd13, 4'd14});
  endfunction

  function automatic exp_t ref_model(input logic [3:0] op, input logic w,
                                     input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] s;
    logic [15:0] r;
    logic [15:0] n;
    logic        c, v;
    e.acc = 0;
    if (eff_wide(op, w)) begin
      c = 1'b0; v = 1'b0; s = 17'd0;
      case (op)
        4'd6:  begin s = {1'b0,a} + {1'b0,b}; r = s[15:0]; c = s[16]; v = (a[15]==b[15]) && (r[15]!=a[15]); end
        4'd8:  begin s = {1'b0,a} - {1'b0,b}; r = s[15:0]; c = (a < b); v = (a[15]!=b[15]) && (r[15]!=a[15]); end
        4'd11: r = a & b;
        4'd12: r = a | b;
        4'd13: r = a ^ b;
        default: r = ~a;
      endcase
      e.data  = r;
      e.flags = {r == 16'd0, r[15], c, v, 4'b0000};
      e.lat   = 3;
    end else begin
      n       = alu_fn(op, a[7:0], b[7:0], 1'b0);
      e.data  = (op inside {4'd0, 4'd2, 4'd3, 4'd15}) ? 16'd0 : {8'd0, n[7:0]};
      e.flags = {n[15:12], 4'b0000};
      e.lat   = 2;
    end
    return e;
  endfunction

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] op, input logic w,
                       input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    bit   ok;
    logic [3:0] hm;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_wide = w; cmd_a = a; cmd_b = b;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    e = ref_model(op, w, a, b);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_a = 16'($urandom); cmd_b = 16'($urandom);
    @(negedge clk);
    chk("lo_mode", {28'd0, alu_mode}, {28'd0, op});
    chk("lo_ops", {16'd0, alu_a, alu_b}, {16'd0, a[7:0], b[7:0]});
    chk("busy_ready", {31'd0, cmd_ready}, 32'd0);
    if (eff_wide(op, w)) begin
      hm = (op == 4'd6) ? 4'd7 : (op == 4'd8) ? 4'd9 : op;
      @(negedge clk);
      chk("hi_mode", {28'd0, alu_mode}, {28'd0, hm});
      chk("hi_ops", {16'd0, alu_a, alu_b}, {16'd0, a[15:8], b[15:8]});
    end
    @(negedge clk);
    chk("resp_mode", {28'd0, alu_mode}, 32'd0);
  endtask

  // ---------------- monitor ----------------
  bit          pend = 1'b0;
  logic [15:0] hold_d;
  logic [7:0]  hold_f;
  exp_t        me;

  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else if (result_valid) begin
      chk("resp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      if (!pend) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", {16'd0, result_data}, 32'hFFFF_FFFF);
        end else begin
          me = sb.pop_front();
          chk("latency", cyc - me.acc, me.lat);
          chk("result_data", {16'd0, result_data}, {16'd0, me.data});
          chk("result_flags", {24'd0, result_flags}, {24'd0, me.flags});
        end
        pend   = 1'b1;
        hold_d = result_data;
        hold_f = result_flags;
      end else begin
        chk("stable", {8'd0, result_data, result_flags}, {8'd0, hold_d, hold_f});
      end
      if (result_ready) pend = 1'b0;
    end
  end

  bit rand_ready = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) result_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !pend) break;
      @(negedge clk);
    end
    chk("drain_empty", sb.size() + int'(pend), 0);
  endtask

  // ---------------- main ----------------
  initial begin
    logic [3:0] rop;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_alu", {12'd0, alu_mode, alu_a, alu_b}, 32'd0);
    chk("rst_result", {8'd0, result_data, result_flags}, 32'd0);

    // directed cases
    issue(4'd6,  1'b0, 16'h0005, 16'h0003);
    issue(4'd6,  1'b1, 16'h01FF, 16'h0001);
    issue(4'd13, 1'b1, 16'hA55A, 16'hA55A);
    issue(4'd10, 1'b1, 16'h0304, 16'h0002);
    issue(4'd8,  1'b1, 16'h0100, 16'h0001);
    issue(4'd0,  1'b0, 16'h1234, 16'h5678);
    drain();

    // reset during the high pass: nothing may come out afterwards
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 4'd6; cmd_wide = 1'b1; cmd_a = 16'h7777; cmd_b = 16'h1111;
    @(negedge clk);
    chk("mid_rst_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_hi_mode", {28'd0, alu_mode}, 32'd7);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", {24'd0, cmd_ready, result_valid, 2'd0, alu_mode}, {24'd0, 1'b1, 1'b0, 6'd0});
    chk("mid_rst_result", {16'd0, result_data}, 32'd0);
    repeat (6) @(negedge clk);

    // backpressure: result held, second command waits until release
    result_ready = 1'b0;
    issue(4'd6, 1'b0, 16'h0012, 16'h0034);
    fork
      issue(4'd12, 1'b1, 16'hF00F, 16'h0FF0);
      begin
        repeat (5) @(negedge clk);
        chk("bp_still_valid", {31'd0, result_valid}, 32'd1);
        @(posedge clk); #1 result_ready = 1'b1;
      end
    join
    drain();

    // randomized traffic with random result backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      do rop = 4'($urandom_range(0, 15)); while (rop == 4'd7 || rop == 4'd9);
      issue(rop, 1'($urandom), 16'($urandom), 16'($urandom));
    end
    drain();
    rand_ready = 1'b0;
    @(posedge clk); #1 result_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
